// File: rtl/satatrn_rxfifo.sv
// SATA transport RX FIFO: buffers each FIS until its last word, then commits it
// whole; aborted or overflowed FISes are rewound. Optional length limit: SATATRN_RXFIFO_MAXLEN_EN.
module satatrn_rxfifo #(
    parameter int LGFIFO        = 4,
    parameter int HOLD_MARGIN   = 4,
    parameter int MAX_FIS_WORDS = 2049
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        s_abort,
    output logic        o_full,
    output logic        o_empty,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        o_success,
    output logic        o_dropped
);
    localparam logic [LGFIFO:0] DEPTH  = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [LGFIFO:0] MARGIN = (LGFIFO+1)'(HOLD_MARGIN);
    localparam logic [LGFIFO:0] ONE    = (LGFIFO+1)'(1);

    logic [32:0]     mem [0:(1<<LGFIFO)-1];

    logic [LGFIFO:0] wr_ptr_q, wr_ptr_d;
    logic [LGFIFO:0] commit_ptr_q, commit_ptr_d;
    logic [LGFIFO:0] rd_ptr_q, rd_ptr_d;
    logic            drop_q, drop_d;
    logic            m_valid_q, m_valid_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            success_q, dropped_q;

    logic [LGFIFO:0] fill, fill_next;
    logic            overflow, too_long, drop_eff;
    logic            accept, commit, discard, rd_en;

`ifdef SATATRN_RXFIFO_MAXLEN_EN
    localparam int LW = $clog2(MAX_FIS_WORDS + 1);
    localparam logic [LW-1:0] MAXW = LW'(MAX_FIS_WORDS);

    logic [LW-1:0] len_q, len_d;

    always_comb begin
        too_long = s_valid && !s_abort && !drop_q && (len_q >= MAXW);
        len_d    = len_q;
        if (commit || discard) begin
            len_d = '0;
        end else if (accept) begin
            len_d = len_q + LW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end
`else
    assign too_long = 1'b0;
`endif

    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        overflow = s_valid && !s_abort && (fill == DEPTH);
        drop_eff = drop_q || overflow || too_long;
        accept   = s_valid && !s_abort && !drop_eff;
        commit   = accept && s_last;
        // A last word that arrives while dropping (including the word that overflows) ends the FIS.
        discard  = s_abort || (s_valid && s_last && drop_eff);
        rd_en    = m_valid_q && m_ready;

        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = drop_eff;
        if (discard) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (commit) begin
            commit_ptr_d = wr_ptr_q + ONE;
        end
        rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;

        fill_next = wr_ptr_d - rd_ptr_d;
        full_d    = (DEPTH - fill_next) <= MARGIN;
        empty_d   = (fill_next == '0);
        // Compared against the pre-commit pointer so m_valid trails the commit edge by one cycle.
        m_valid_d = (rd_ptr_d != commit_ptr_q);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            success_q    <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_q       <= drop_d;
            m_valid_q    <= m_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            success_q    <= commit;
            dropped_q    <= discard;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_ptr_q[LGFIFO-1:0]] <= {s_last, s_data};
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = mem[rd_ptr_q[LGFIFO-1:0]][31:0];
    assign m_last    = mem[rd_ptr_q[LGFIFO-1:0]][32];
    assign o_full    = full_q;
    assign o_empty   = empty_q;
    assign o_success = success_q;
    assign o_dropped = dropped_q;

endmodule
